// File: rtl/cla_multibyte_seq_if.sv
// Operand/result handshake bundle for cla_multibyte_seq.
//   in_valid/in_ready/in_a/in_b/in_cin : request channel. The upstream side drives valid and the operands.
//   out_valid/out_ready/out_sum        : result channel. out_sum is {final carry, sum}.
// The slave modport is the sequencer's view of the bundle. The master modport is the view of the
// client that issues requests and takes results.
interface cla_multibyte_seq_if #(
  parameter int unsigned NBYTES = 2
) ();
  logic                  in_valid;
  logic                  in_ready;
  logic [8*NBYTES-1:0]   in_a;
  logic [8*NBYTES-1:0]   in_b;
  logic                  in_cin;
  logic                  out_valid;
  logic                  out_ready;
  logic [8*NBYTES:0]     out_sum;

  modport slave (
    input  in_valid, in_a, in_b, in_cin, out_ready,
    output in_ready, out_valid, out_sum
  );

  modport master (
    output in_valid, in_a, in_b, in_cin, out_ready,
    input  in_ready, out_valid, out_sum
  );
endinterface

// File: rtl/cla_multibyte_seq.sv
// Multi-byte adder sequencer around an external 8-bit carry-lookahead adder (CLA8).
// It accepts two 8*NBYTES-bit operands and a carry-in on bus. It feeds CLA8 one byte per cycle,
// least significant byte first, and passes the carry from byte to byte through a register. The
// (8*NBYTES+1)-bit sum is returned on bus.
//   clk, rst_n        : clock (rising edge) and asynchronous active-low reset.
//   bus (slave)       : request and result handshakes, see cla_multibyte_seq_if.
//   cla_a/cla_b       : operand bytes presented to CLA8. They are zero outside ADD.
//   cla_cin           : carry presented to CLA8. It is zero outside ADD.
//   cla_sum           : CLA8 result {carry_out, sum[7:0]}. It is combinational from cla_a/cla_b/cla_cin.
module cla_multibyte_seq #(
  parameter int unsigned NBYTES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  cla_multibyte_seq_if.slave  bus,
  output logic [7:0]          cla_a,
  output logic [7:0]          cla_b,
  output logic                cla_cin,
  input  logic [8:0]          cla_sum
);

  localparam int unsigned W  = 8 * NBYTES;
  localparam int unsigned IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    DONE
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W:0]      res_q, res_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            carry_q, carry_d;
  logic            in_ready_c;
  logic            out_valid_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    res_d       = res_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    cla_a       = '0;
    cla_b       = '0;
    cla_cin     = 1'b0;

    unique case (state_q)
      IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) begin
          a_d     = bus.in_a;
          b_d     = bus.in_b;
          carry_d = bus.in_cin;
          idx_d   = '0;
          state_d = ADD;
        end
      end

      ADD: begin
        // CLA8 inputs come only from registers, so in_* have no combinational path to cla_*.
        cla_a   = a_q[8*idx_q +: 8];
        cla_b   = b_q[8*idx_q +: 8];
        cla_cin = carry_q;
        res_d[8*idx_q +: 8] = cla_sum[7:0];
        carry_d = cla_sum[8];
        if (idx_q == LAST) begin
          res_d[W] = cla_sum[8];
          idx_d    = '0;
          state_d  = DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end

      DONE: begin
        out_valid_c = 1'b1;
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // out_sum follows the result register. It keeps the last sum after the handshake.
  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.out_sum   = res_q;

endmodule

// File: tb/tb_cla_multibyte_seq.sv
module tb_cla_multibyte_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic rst_rand_n;
  int   total = 0;
  int   bad   = 0;

  task automatic check_eq(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- directed instance, NBYTES=2 ----------------
  cla_multibyte_seq_if #(.NBYTES(2)) dif ();
  logic [7:0] d_cla_a, d_cla_b;
  logic       d_cla_cin;
  logic [8:0] d_cla_sum;
  assign d_cla_sum = {1'b0, d_cla_a} + {1'b0, d_cla_b} + {8'd0, d_cla_cin};

  cla_multibyte_seq #(.NBYTES(2)) u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (dif),
    .cla_a   (d_cla_a),
    .cla_b   (d_cla_b),
    .cla_cin (d_cla_cin),
    .cla_sum (d_cla_sum)
  );

  logic [16:0] d_exp_q[$];

  always @(negedge clk) begin
    if (rst_n && dif.out_valid && dif.out_ready) begin
      if (d_exp_q.size() == 0) check_eq("d_sb_size", d_exp_q.size(), 1);
      else check_eq("d_sum", dif.out_sum, d_exp_q.pop_front());
    end
  end

  task automatic d_send(input logic [15:0] a, input logic [15:0] b, input logic cin);
    int n;
    n = 0;
    @(posedge clk); #1;
    dif.in_valid = 1'b1; dif.in_a = a; dif.in_b = b; dif.in_cin = cin;
    @(negedge clk);
    while (!dif.in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    check_eq("d_accept_ready", dif.in_ready, 1);
    @(posedge clk); #1;
    dif.in_valid = 1'b0;
    d_exp_q.push_back({1'b0, a} + {1'b0, b} + {16'd0, cin});
  endtask

  task automatic d_wait_done();
    int n;
    n = 0;
    @(negedge clk);
    while (!dif.out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check_eq("d_done", dif.out_valid, 1);
  endtask

  // ---------------- back-to-back random instances, NBYTES = 1, 2, 4 ----------------
  for (genvar gi = 0; gi < 3; gi++) begin : gr
    localparam int unsigned NB = (gi == 0) ? 1 : (gi == 1) ? 2 : 4;
    localparam int unsigned W  = 8 * NB;

    cla_multibyte_seq_if #(.NBYTES(NB)) rif ();
    logic [7:0] ca, cb;
    logic       cc;
    logic [8:0] cs;
    assign cs = {1'b0, ca} + {1'b0, cb} + {8'd0, cc};

    cla_multibyte_seq #(.NBYTES(NB)) u_dut (
      .clk     (clk),
      .rst_n   (rst_rand_n),
      .bus     (rif),
      .cla_a   (ca),
      .cla_b   (cb),
      .cla_cin (cc),
      .cla_sum (cs)
    );

    logic [W:0] q[$];
    bit fin  = 1'b0;
    int cyc  = 0;
    int last = -1;
    int got  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
      if (rst_rand_n && rif.out_valid && rif.out_ready) begin
        if (q.size() == 0) check_eq($sformatf("r%0d_sb_size", NB), q.size(), 1);
        else check_eq($sformatf("r%0d_sum", NB), rif.out_sum, q.pop_front());
        if (last >= 0) check_eq($sformatf("r%0d_spacing", NB), cyc - last, NB + 2);
        last = cyc;
        got++;
      end
    end

    initial begin : drv
      int acc;
      int n;
      acc = 0;
      n = 0;
      rif.in_valid = 1'b0; rif.out_ready = 1'b1;
      rif.in_a = '1; rif.in_b = '1; rif.in_cin = 1'b1;
      wait (rst_rand_n === 1'b1);
      @(posedge clk); #1;
      rif.in_valid = 1'b1;
      while (acc < 100 && n < 100 * (NB + 2) + 100) begin
        @(negedge clk);
        n++;
        if (rif.in_ready) begin
          q.push_back({1'b0, rif.in_a} + {1'b0, rif.in_b} + (W + 1)'(rif.in_cin));
          acc++;
          @(posedge clk); #1;
          rif.in_a   = W'({$urandom(), $urandom()});
          rif.in_b   = W'({$urandom(), $urandom()});
          rif.in_cin = 1'($urandom_range(0, 1));
          if (acc == 100) rif.in_valid = 1'b0;
        end
      end
      n = 0;
      while (got < 100 && n < 40) begin
        @(negedge clk);
        n++;
      end
      check_eq($sformatf("r%0d_count", NB), got, 100);
      fin = 1'b1;
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    rst_n = 1'b0; rst_rand_n = 1'b0;
    dif.in_valid = 1'b0; dif.in_a = '0; dif.in_b = '0; dif.in_cin = 1'b0; dif.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_in_ready", dif.in_ready, 1);
    check_eq("rst_out_valid", dif.out_valid, 0);
    check_eq("rst_out_sum", dif.out_sum, 0);
    check_eq("rst_cla", {d_cla_a, d_cla_b, d_cla_cin}, 0);
    rst_n = 1'b1; rst_rand_n = 1'b1;
    dif.out_ready = 1'b1;

    // 0x00FF + 0x0001: carry ripples into byte 1
    d_send(16'h00FF, 16'h0001, 1'b0);
    @(negedge clk);
    check_eq("add0_cla_a", d_cla_a, 8'hFF);
    check_eq("add0_cla_b", d_cla_b, 8'h01);
    check_eq("add0_cla_cin", d_cla_cin, 0);
    check_eq("add0_out_valid", dif.out_valid, 0);
    @(negedge clk);
    check_eq("add1_cla_cin", d_cla_cin, 1);
    check_eq("add1_cla_ab", {d_cla_a, d_cla_b}, 16'h0000);
    check_eq("add1_out_valid", dif.out_valid, 0);
    @(negedge clk);
    check_eq("latency_out_valid", dif.out_valid, 1);
    check_eq("done_in_ready", dif.in_ready, 0);
    @(negedge clk);
    check_eq("idle_in_ready", dif.in_ready, 1);
    check_eq("idle_cla", {d_cla_a, d_cla_b, d_cla_cin}, 0);

    // boundaries
    d_send(16'hFFFF, 16'hFFFF, 1'b1);
    d_wait_done();
    d_send(16'h0000, 16'h0000, 1'b1);
    d_wait_done();

    // result held under back-pressure, request while busy ignored
    d_send(16'h1234, 16'h4321, 1'b0);
    dif.out_ready = 1'b0;
    d_wait_done();
    for (int i = 0; i < 5; i++) begin
      check_eq("hold_out_valid", dif.out_valid, 1);
      check_eq("hold_out_sum", dif.out_sum, 17'h05555);
      check_eq("hold_in_ready", dif.in_ready, 0);
      @(posedge clk); #1;
      dif.in_valid = (i == 1);
      dif.in_a = 16'hDEAD; dif.in_b = 16'hBEEF; dif.in_cin = 1'b1;
      @(negedge clk);
    end
    @(posedge clk); #1;
    dif.out_ready = 1'b1;
    @(negedge clk);
    repeat (3) begin
      @(negedge clk);
      check_eq("post_hold_idle", {dif.in_ready, dif.out_valid}, 2'b10);
    end
    d_send(16'h0101, 16'h0202, 1'b0);
    d_wait_done();

    // reset mid-ADD, after byte 0
    d_send(16'h1111, 16'h2222, 1'b0);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_eq("rstadd_out_valid", dif.out_valid, 0);
    check_eq("rstadd_in_ready", dif.in_ready, 1);
    check_eq("rstadd_cla", {d_cla_a, d_cla_b, d_cla_cin}, 0);
    d_exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;

    // reset in DONE
    @(posedge clk); #1;
    dif.out_ready = 1'b0;
    d_send(16'h3333, 16'h4444, 1'b1);
    d_wait_done();
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("rstdone_out_valid", dif.out_valid, 0);
    check_eq("rstdone_out_sum", dif.out_sum, 0);
    check_eq("rstdone_in_ready", dif.in_ready, 1);
    d_exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    dif.out_ready = 1'b1;
    d_send(16'h00AA, 16'h0055, 1'b0);
    d_wait_done();
    @(negedge clk);
    check_eq("d_sb_drained", d_exp_q.size(), 0);

    n = 0;
    while (!(gr[0].fin && gr[1].fin && gr[2].fin) && n < 3000) begin
      @(posedge clk);
      n++;
    end
    check_eq("rand_finished", {gr[0].fin, gr[1].fin, gr[2].fin}, 3'b111);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
